// File: rtl/sel_button_conditioner.sv
// Input stage for data_selector: synchronises A/B, debounces the select
// pushbutton and toggles a registered select on every accepted press.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | button seen pressed, counting stable cycles
// PRESSED      | press accepted (PRESS pulsed, SEL toggled), waiting for release
// RELEASE_WAIT | button seen released, counting stable cycles
module sel_button_conditioner #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter logic SEL_RESET       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    input  logic a_in,
    input  logic b_in,
    output logic sel,
    output logic a,
    output logic b,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   btn;

    // Data synchronisers clear to 0; no filtering, fixed SYNC_STAGES latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    // Button synchroniser presets to released so reset never looks like a press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '1;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign a   = a_sync[SYNC_STAGES-1];
    assign b   = b_sync[SYNC_STAGES-1];
    assign btn = ~btn_sync[SYNC_STAGES-1];

    // Debounce FSM with its stability counter and the registered SEL/PRESS outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= SEL_RESET;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (btn) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        press <= 1'b1;
                        sel   <= ~sel;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    cnt <= '0;
                    if (!btn) begin
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_button_conditioner.sv
// Directed bench for sel_button_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
module tb_sel_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_n;
    logic a_in;
    logic b_in;
    logic sel;
    logic a;
    logic b;
    logic press;

    int   checks   = 0;
    int   failures = 0;
    logic exp_sel;
    logic exp_a;

    sel_button_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .SEL_RESET      (1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_n),
        .a_in (a_in),
        .b_in (b_in),
        .sel  (sel),
        .a    (a),
        .b    (b),
        .press(press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold btn_n at lvl for n cycles; no PRESS is allowed, SEL must not move.
    task automatic hold_no_press(input logic lvl, input int n, input string tag);
        btn_n = lvl;
        for (int i = 1; i <= n; i++) begin
            step();
            check({tag, "_press"}, press, 1'b0);
            check({tag, "_sel"}, sel, exp_sel);
        end
    endtask

    // Hold the button low for n cycles from a debounced-idle state:
    // PRESS must fire exactly on the 11th edge (2 sync + 1 + 8 debounce).
    task automatic press_hold(input int n, input string tag);
        btn_n = 1'b0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (i == 11) exp_sel = ~exp_sel;
            check({tag, "_press"}, press, (i == 11) ? 1'b1 : 1'b0);
            check({tag, "_sel"}, sel, exp_sel);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_n   = 1'b1;
        a_in    = 1'b0;
        b_in    = 1'b0;
        exp_sel = 1'b0;
        #1;

        // 1. reset state, then idle
        check("rst_sel", sel, 1'b0);
        check("rst_press", press, 1'b0);
        check("rst_a", a, 1'b0);
        check("rst_b", b, 1'b0);
        step(); step(); step();
        rst_n = 1'b1;
        hold_no_press(1'b1, 50, "idle");

        // 2. clean press held 30 cycles, then clean release
        press_hold(30, "clean");
        hold_no_press(1'b1, 20, "clean_rel");

        // 3. bounce rejection, then a real press
        hold_no_press(1'b0, 5, "bnc_low1");
        hold_no_press(1'b1, 2, "bnc_high");
        hold_no_press(1'b0, 5, "bnc_low2");
        hold_no_press(1'b1, 20, "bnc_rel");
        press_hold(20, "bnc_press");

        // 4. release bounce while held, then next clean press
        hold_no_press(1'b1, 3, "rb_high1");
        hold_no_press(1'b0, 2, "rb_low");
        hold_no_press(1'b1, 20, "rb_high2");
        press_hold(20, "rb_press");
        hold_no_press(1'b1, 20, "rb_rel");

        // 5. synchroniser path: A_IN 1,0,1 every 4 cycles, B_IN held 1
        b_in = 1'b1;
        step(); step(); step();
        check("sync_b_settled", b, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            if (i == 1 || i == 5 || i == 9) begin
                exp_a = (i == 5) ? 1'b1 : ((i == 1) ? 1'b0 : 1'b0);
                a_in  = (i == 5) ? 1'b0 : 1'b1;
                #1;
                check("sync_a_no_async_change", a, exp_a);
            end
            step();
            exp_a = ((i >= 2 && i <= 5) || i >= 10) ? 1'b1 : 1'b0;
            check("sync_a", a, exp_a);
            check("sync_b", b, 1'b1);
        end

        // 6. reset at debounce count 5 with button held, then press after release
        check("pre_rst_sel", sel, 1'b1);
        hold_no_press(1'b0, 8, "mid_cnt");
        rst_n = 1'b0;
        #1;
        exp_sel = 1'b0;
        check("mid_rst_sel", sel, 1'b0);
        check("mid_rst_press", press, 1'b0);
        step(); step(); step();
        check("mid_rst_hold_sel", sel, 1'b0);
        rst_n = 1'b1;
        press_hold(20, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
